// File: rtl/cordic_vectoring_if.sv
// Handshake bundle for cordic_vectoring: Q1.15 vector in, polar result out.
interface cordic_vectoring_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               out_valid;
  logic               out_ready;
  logic        [15:0] mag_out;
  logic signed [15:0] angle_out;

  modport master (output in_valid, x_in, y_in, out_ready,
                  input  in_ready, out_valid, mag_out, angle_out);
  modport slave  (input  in_valid, x_in, y_in, out_ready,
                  output in_ready, out_valid, mag_out, angle_out);
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: Q1.15 (x, y) -> magnitude and atan2 angle (0x2000 = pi/4).
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain from mag_out.
module cordic_vectoring #(
  parameter int unsigned ITER = 8
) (
  input  logic              clk,
  input  logic              rst,
  cordic_vectoring_if.slave bus
);
  localparam int unsigned DW = 18;
  localparam int unsigned ZW = 17;
  localparam int unsigned KW = 4;
  localparam logic [KW-1:0]        K_LAST    = KW'(ITER - 1);
  localparam logic signed [ZW-1:0] Z_QUARTER = 17'sh04000;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int unsigned          PW        = 34;
  localparam logic signed [15:0]   GAIN_K    = 16'sh4DBA;
`endif

  if ((ITER < 4) || (ITER > 12)) begin : g_iter_check
    $error("cordic_vectoring: ITER must be within 4..12");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, SCALE = 2'd2, DONE = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic signed [DW-1:0] x_q, y_q, x_nxt, y_nxt, x_cap, y_cap, xe, ye, x_sh, y_sh;
  logic signed [ZW-1:0] z_q, z_nxt, z_cap, atan_k;
  logic                 cap_c, step_c, load_c, clr_c;
  logic                 out_valid_q;
  logic [15:0]          mag_q, angle_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ROT;
      ROT:     if (k_q == K_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                 state_d = SCALE;
`else
                 state_d = DONE;
`endif
               end
      SCALE:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    cap_c  = 1'b0;
    step_c = 1'b0;
    load_c = 1'b0;
    clr_c  = 1'b0;
    case (state_q)
      IDLE:  cap_c = bus.in_valid;
      ROT: begin
        step_c = 1'b1;
`ifndef CORDIC_GAIN_COMP_EN
        load_c = (k_q == K_LAST);
`endif
      end
      SCALE: begin
`ifdef CORDIC_GAIN_COMP_EN
        load_c = 1'b1;
`endif
      end
      DONE:    clr_c = bus.out_ready;
      default: ;
    endcase
  end

  assign bus.in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    atan_k = '0;
    case (k_q)
      4'd0:    atan_k = 17'sh02000;
      4'd1:    atan_k = 17'sh012E4;
      4'd2:    atan_k = 17'sh009FB;
      4'd3:    atan_k = 17'sh00511;
      4'd4:    atan_k = 17'sh0028B;
      4'd5:    atan_k = 17'sh00146;
      4'd6:    atan_k = 17'sh000A3;
      4'd7:    atan_k = 17'sh00051;
      4'd8:    atan_k = 17'sh00029;
      4'd9:    atan_k = 17'sh00014;
      4'd10:   atan_k = 17'sh0000A;
      4'd11:   atan_k = 17'sh00005;
      default: atan_k = '0;
    endcase
  end

  // Quadrant pre-rotation into the right half-plane; widen before negating so -1.0 maps to +1.0
  always_comb begin
    xe = {{(DW-16){bus.x_in[15]}}, bus.x_in};
    ye = {{(DW-16){bus.y_in[15]}}, bus.y_in};
    if (!bus.x_in[15]) begin
      x_cap = xe;
      y_cap = ye;
      z_cap = '0;
    end else if (!bus.y_in[15]) begin
      x_cap = ye;
      y_cap = -xe;
      z_cap = Z_QUARTER;
    end else begin
      x_cap = -ye;
      y_cap = xe;
      z_cap = -Z_QUARTER;
    end
  end

  always_comb begin
    x_sh = x_q >>> k_q;
    y_sh = y_q >>> k_q;
    if (!y_q[DW-1]) begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + atan_k;
    end else begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - atan_k;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (cap_c) begin
      k_q <= '0;
      x_q <= x_cap;
      y_q <= y_cap;
      z_q <= z_cap;
    end else if (step_c) begin
      k_q <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
      x_q <= x_nxt;
      y_q <= y_nxt;
      z_q <= z_nxt;
    end
  end

  // Result registers; held stable through DONE until the consumer accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      angle_q     <= '0;
    end else if (load_c) begin
      out_valid_q <= 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
      mag_q       <= 16'((PW'(x_q) * PW'(GAIN_K)) >>> 15);
      angle_q     <= z_q[15:0];
`else
      mag_q       <= x_nxt[16:1];
      angle_q     <= z_nxt[15:0];
`endif
    end else if (clr_c) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.mag_out   = mag_q;
  assign bus.angle_out = angle_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed self-checking bench for cordic_vectoring at ITER = 8, either gain-compensation build.
module tb_cordic_vectoring;
  localparam int unsigned ITER = 8;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 1;
`else
  localparam int LAT = ITER;
`endif
  localparam int MAX_WAIT = 60;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] snap_mag, snap_ang;

  cordic_vectoring_if bif ();
  cordic_vectoring #(.ITER(ITER)) dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  // Ideal magnitude in the output format of this build (Q2.14 of 1.6468*|v| without compensation)
  function automatic int exp_mag(input int m);
`ifdef CORDIC_GAIN_COMP_EN
    return m;
`else
    return (m * 13490) / 16384;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ang(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    logic signed [15:0] d;
    logic ok;
    d  = obs - exp;
    ok = (int'(d) >= -96) && (int'(d) <= 96);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h +/-60", tag, obs, exp);
    end
  endtask

  task automatic chk_mag(input string tag, input logic [15:0] obs, input int exp);
    int  d;
    logic ok;
    d  = int'(obs) - exp;
    ok = (d >= -64) && (d <= 64);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h +/-40", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bif.in_ready), 32'd1);
    bif.x_in     = x;
    bif.y_in     = y;
    bif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (bif.out_valid !== 1'b1 && n < MAX_WAIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bif.out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bif.in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] ea, input int em);
    send(tag, x, y);
    wait_out(tag);
    chk_ang({tag, "_angle"}, bif.angle_out, ea);
    chk_mag({tag, "_mag"}, bif.mag_out, em);
    ack(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.x_in      = '0;
    bif.y_in      = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_mag",       32'(bif.mag_out),   32'd0);
    chk("rst_angle",     32'(bif.angle_out), 32'd0);
    chk("rst_in_ready",  32'(bif.in_ready),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("idle_in_ready", 32'(bif.in_ready), 32'd1);

    run("east", 16'h4000, 16'h0000, 16'h0000, exp_mag(16384));

    // Diagonal result held under backpressure while a stray in_valid is offered
    send("diag", 16'h2D41, 16'h2D41);
    wait_out("diag");
    chk_ang("diag_angle", bif.angle_out, 16'h2000);
    chk_mag("diag_mag", bif.mag_out, exp_mag(16384));
    snap_mag     = bif.mag_out;
    snap_ang     = bif.angle_out;
    bif.x_in     = 16'h1234;
    bif.y_in     = 16'h7000;
    bif.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bif.out_valid), 32'd1);
      chk("hold_ready", 32'(bif.in_ready),  32'd0);
      chk("hold_mag",   32'(bif.mag_out),   32'(snap_mag));
      chk("hold_angle", 32'(bif.angle_out), 32'(snap_ang));
    end
    bif.in_valid = 1'b0;
    ack("diag");
    repeat (3) @(posedge clk);
    #1 chk("no_ghost_result", 32'(bif.out_valid), 32'd0);

    run("q3",   16'hC000, 16'hC000, 16'hA000, exp_mag(23170));
    run("q2",   16'hC000, 16'h4000, 16'h6000, exp_mag(23170));
    run("q4",   16'h4000, 16'hC000, 16'hE000, exp_mag(23170));
    run("west", 16'h8000, 16'h0000, 16'h8000, exp_mag(32768));

    // Asynchronous reset mid-rotation at k = 3, between clock edges
    send("abort", 16'h3000, 16'h1000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bif.out_valid), 32'd0);
    chk("abort_mag",       32'(bif.mag_out),   32'd0);
    chk("abort_angle",     32'(bif.angle_out), 32'd0);
    chk("abort_in_ready",  32'(bif.in_ready),  32'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("abort_idle_ready", 32'(bif.in_ready), 32'd1);

    run("north", 16'h0000, 16'h4000, 16'h4000, exp_mag(16384));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
